// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared opcode-class encodings, FSM state encodings and register-usage helpers
//   Macros   : `Rtype `ItypeL `ItypeA `ItypeJ `Stype `Btype `UtypeU `Jtype (5-bit opcode classes)
//              `HC_RUN `HC_MEM_WAIT (hazard controller FSM states)
//   Package  : op_t, hc_state_t, rs1_used(), rs2_used()
`ifndef HAZARD_CTRL_DEFS
`define HAZARD_CTRL_DEFS
`define Rtype       5'd0
`define ItypeL      5'd1
`define ItypeA      5'd2
`define ItypeJ      5'd3
`define Stype       5'd4
`define Btype       5'd5
`define UtypeU      5'd6
`define Jtype       5'd7
`define HC_RUN      1'b0
`define HC_MEM_WAIT 1'b1
`endif

package hazard_ctrl_pkg;

    typedef logic [4:0] op_t;

    localparam op_t OP_RTYPE  = `Rtype;
    localparam op_t OP_STYPE  = `Stype;
    localparam op_t OP_BTYPE  = `Btype;
    localparam op_t OP_UTYPEU = `UtypeU;
    localparam op_t OP_JTYPE  = `Jtype;

    typedef enum logic {
        HC_RUN      = `HC_RUN,
        HC_MEM_WAIT = `HC_MEM_WAIT
    } hc_state_t;

    // LUI/AUIPC and JAL carry no rs1 field; everything else reads rs1.
    function automatic logic rs1_used(input op_t op);
        return !(op == OP_UTYPEU || op == OP_JTYPE);
    endfunction

    function automatic logic rs2_used(input op_t op);
        return op == OP_RTYPE || op == OP_STYPE || op == OP_BTYPE;
    endfunction

endpackage

// File: rtl/hazard_mem_wait.sv
// hazard_mem_wait: data-memory wait FSM with timeout watchdog
//   clk, rst     : clock, synchronous active-high reset
//   mem_req      : MEM-stage instruction accesses data memory
//   dmem_ack     : memory completes the access this cycle
//   mem_stall    : pipeline must hold for the MEM access (same cycle)
//   mem_timeout  : one-cycle pulse on forced release
//   mem_err      : sticky timeout flag, cleared only by rst
module hazard_mem_wait
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic dmem_ack,
    output logic mem_stall,
    output logic mem_timeout,
    output logic mem_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    hc_state_t     state;
    logic [CW-1:0] wait_cnt;
    logic          at_limit;

    // wait_cnt counts stall cycles already spent on the current access,
    // so reaching LIMIT means the budget is exhausted this cycle.
    always_comb begin
        at_limit    = wait_cnt == LIMIT;
        mem_stall   = !rst && (state == HC_RUN ? mem_req && !dmem_ack : !dmem_ack && !at_limit);
        mem_timeout = !rst && state == HC_MEM_WAIT && !dmem_ack && at_limit;
    end

    // mem_req is not sampled in MEM_WAIT: the MEM stage is frozen while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HC_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else if (state == HC_RUN) begin
            if (mem_req && !dmem_ack) begin
                state    <= HC_MEM_WAIT;
                wait_cnt <= CW'(1);
            end
        end else if (dmem_ack || at_limit) begin
            state    <= HC_RUN;
            wait_cnt <= '0;
            mem_err  <= mem_err || !dmem_ack;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing for the 5-stage core
//   clk, rst                      : clock, synchronous active-high reset
//   id_inst_op, id_rs1, id_rs2    : ID instruction opcode class and sources
//   ex_rd, ex_mem_read            : EX destination and load flag
//   ex_br_taken                   : EX branch/jump resolved taken
//   mem_req, dmem_ack             : MEM access request and memory completion
//   pc_stall .. mem_wb_bubble     : pipeline register enables/clears
//   mem_timeout, mem_err          : watchdog pulse and sticky error
//   stall_cycles                  : count of cycles with pc_stall=1 (wraps)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_inst_op,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              dmem_ack,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic              mem_wb_bubble,
    output logic              mem_timeout,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cycles
);

    logic mem_stall;
    logic load_use;

    hazard_mem_wait #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .dmem_ack   (dmem_ack),
        .mem_stall  (mem_stall),
        .mem_timeout(mem_timeout),
        .mem_err    (mem_err)
    );

    // Priority: MEM stall freezes everything (a taken branch waits in EX),
    // then a taken branch squashes ID (hiding any load-use), then load-use.
    always_comb begin
        load_use      = ex_mem_read && ex_rd != 5'd0 &&
                        ((rs1_used(id_inst_op) && id_rs1 == ex_rd) ||
                         (rs2_used(id_inst_op) && id_rs2 == ex_rd));
        pc_stall      = mem_stall || (!rst && !ex_br_taken && load_use);
        if_id_stall   = pc_stall;
        id_ex_stall   = mem_stall;
        ex_mem_stall  = mem_stall;
        mem_wb_bubble = mem_stall;
        if_id_flush   = !rst && !mem_stall && ex_br_taken;
        id_ex_flush   = !rst && !mem_stall && (ex_br_taken || load_use);
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (pc_stall)
            stall_cycles <= stall_cycles + PERF_W'(1);
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Generates per-stage stall and flush/bubble controls from three sources:
  - load-use hazards between ID and EX;
  - taken branches and jumps resolved in EX;
  - multi-cycle data-memory accesses in MEM, using a req/ack handshake with a timeout watchdog.
- Sits beside the main decoder and drives the enables and clears of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Also keeps a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16, total stall cycles allowed for one MEM access before a forced release and error (legal range ≥2).
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_inst_op  in  5  opcode class of the ID instruction (shared `Rtype/`ItypeL/... encodings).
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- ex_rd  in  5  EX destination register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_br_taken  in  1  EX branch/jump resolved taken.
- mem_req  in  1  MEM instruction accesses data memory (load or store).
- dmem_ack  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_stall  out  1  hold ID/EX.
- id_ex_flush  out  1  load a bubble into ID/EX.
- ex_mem_stall  out  1  hold EX/MEM.
- mem_wb_bubble  out  1  write a bubble into MEM/WB.
- mem_timeout  out  1  one-cycle pulse on forced release.
- mem_err  out  1  sticky timeout flag.
- stall_cycles  out  PERF_W  count of cycles with pc_stall=1.

Behaviour:

Reset:
- While rst=1, all stall/flush/bubble outputs are forced 0 and mem_timeout is 0.
- Registered state on the rst edge: FSM=RUN, wait_cnt=0, mem_err=0, stall_cycles=0.
- Reset mid-wait abandons the access and returns to RUN.

Register usage, decoded from id_inst_op:
- rs1_used = not (`UtypeU or `Jtype).
- rs2_used = `Rtype, `Stype or `Btype.

Control terms (combinational, same-cycle):
- load_use = ex_mem_read & ex_rd≠0 & ((rs1_used & id_rs1==ex_rd) | (rs2_used & id_rs2==ex_rd)).
- mem_stall:
  - in RUN: mem_req & ~dmem_ack;
  - in MEM_WAIT: ~dmem_ack & wait_cnt≠MEM_TIMEOUT.

Priority 1, mem_stall:
- pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are 1; mem_wb_bubble is 1.
- All flushes are 0.
- A taken branch is deferred: EX is frozen, so ex_br_taken persists and flushes after release.

Priority 2, ex_br_taken:
- if_id_flush=1 and id_ex_flush=1; no stalls.
- load_use is ignored because the ID instruction is squashed.

Priority 3, load_use:
- pc_stall=1, if_id_stall=1, id_ex_flush=1.
- Exactly one bubble: next cycle the load is in MEM and load_use falls.

Otherwise all controls are 0.

FSM (states RUN, MEM_WAIT):
- RUN:
  - mem_req & ~dmem_ack → MEM_WAIT, wait_cnt←1.
  - mem_req & dmem_ack → single-cycle access, no stall, stay in RUN.
- MEM_WAIT:
  - dmem_ack → release, RUN, wait_cnt←0.
  - Else if wait_cnt==MEM_TIMEOUT → release, mem_timeout=1, mem_err←1, RUN, wait_cnt←0.
  - Else keep stalling, wait_cnt←wait_cnt+1.
  - dmem_ack arriving on the timeout cycle counts as a normal ack: no error.
- A never-acked access therefore stalls exactly MEM_TIMEOUT cycles.

Counters:
- wait_cnt width is $clog2(MEM_TIMEOUT+1).
- stall_cycles increments when pc_stall=1 and wraps modulo 2^PERF_W.
- mem_err clears only on rst.

Decomposition:
- Shared define file: opcode class encodings (`Rtype, `ItypeL, `ItypeA, `ItypeJ, `Stype, `Btype, `UtypeU, `Jtype).
- New constants in the shared define file: FSM state encodings HC_RUN/HC_MEM_WAIT.
- One natural sub-module: hazard_mem_wait, containing the FSM, wait_cnt and the timeout logic, and producing mem_stall and mem_timeout.
- Load-use/branch priority logic and the perf counter stay in the top level.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID `Rtype with rs2=5 → one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cycles 0→1.
- Same load with ex_rd=0, or ID `UtypeU with rs1=5 → all controls 0.
- ex_br_taken=1 together with load_use=1 → if_id_flush=1, id_ex_flush=1, pc_stall=0.
- mem_req=1, dmem_ack raised on the 4th cycle → stalls and mem_wb_bubble=1 for 3 cycles; released on cycle 4; mem_err=0; stall_cycles=3.
- mem_req=1, never acked, MEM_TIMEOUT=16 → 16 stall cycles; mem_timeout pulses on cycle 17; mem_err=1 sticky.
- ex_br_taken=1 during a MEM wait → no flush until the ack; flush in the release cycle. Separately: rst=1 mid-wait → outputs 0, FSM RUN, mem_err=0, stall_cycles=0.
